// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencing controller.
//   - FSM state type (IDLE/DECODE/EXEC/WB)
//   - instruction field bit positions for the 18-bit instruction word
//   - "clear flags" encoding detector
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      WB     = 2'd3
   } state_t;

   // Instruction field map (fixed for an 18-bit word)
   localparam int unsigned OP_HI   = 17;
   localparam int unsigned OP_LO   = 15;
   localparam int unsigned IMM_EN  = 14;
   localparam int unsigned ZSRC    = 13;
   localparam int unsigned WEN     = 12;
   localparam int unsigned DST_HI  = 11;
   localparam int unsigned DST_LO  = 10;
   localparam int unsigned SRC0_HI = 9;
   localparam int unsigned SRC0_LO = 8;
   localparam int unsigned IMM_HI  = 7;
   localparam int unsigned IMM_LO  = 0;

   // Clear-flags encoding: op=000, imm_en=1, zsrc=1, wen=0, imm8=0 (dst/src0 don't care)
   localparam logic [2:0] CLR_OP   = 3'b000;

   function automatic logic is_clear_flags(input logic [17:0] ins);
      return (ins[OP_HI:OP_LO] == CLR_OP) && ins[IMM_EN] && ins[ZSRC] &&
             !ins[WEN] && (ins[IMM_HI:IMM_LO] == 8'h00);
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational field extraction from the latched
// instruction word, plus sign-extension of imm8 to DW+1 bits.
// Ports:
//   instr   in   latched instruction word
//   op      out  ALU operation
//   imm_en  out  immediate select for ALU input 1
//   zsrc    out  force ALU input 0 to zero
//   wen     out  write-back enable
//   dst     out  write-back register
//   src0    out  read port 0 register
//   rd1     out  read port 1 register (imm8 low bits)
//   imm     out  sign-extended immediate
module alu_seq_decode
   import alu_seq_pkg::*;
#(
   parameter int IW = 18,
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic [IW-1:0] instr,
   output logic [2:0]    op,
   output logic          imm_en,
   output logic          zsrc,
   output logic          wen,
   output logic [AW-1:0] dst,
   output logic [AW-1:0] src0,
   output logic [AW-1:0] rd1,
   output logic [DW:0]   imm
);

   always_comb begin
      op     = instr[OP_HI:OP_LO];
      imm_en = instr[IMM_EN];
      zsrc   = instr[ZSRC];
      wen    = instr[WEN];
      dst    = instr[DST_HI:DST_LO];
      src0   = instr[SRC0_HI:SRC0_LO];
      // Port 1 address is the low imm8 bits; only meaningful when imm_en=0
      rd1    = instr[IMM_LO+AW-1:IMM_LO];
      imm    = {{(DW-7){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle controller sequencing the ALU/register-file
// datapath, one instruction per IDLE->DECODE->EXEC->WB pass (4 cycles).
// Optional build macro: ALU_SEQ_STICKY_OVF_EN (sticky overflow flag,
// cleared by reset or by retiring the clear-flags encoding).
// Ports:
//   clk, rst (async, active-low)
//   instr/instr_valid/instr_ready   instruction handshake
//   rd0_addr, rd1_addr, wr_addr      register-file addresses
//   reg_read, reg_write              register-file enables
//   alu_src0, alu_src1, alu_op, imm  ALU controls
//   alu_result, alu_ovf, alu_zero    ALU outputs
//   wr_data                          sign-extended write-back data
//   done, flag_ovf, flag_zero        retirement pulse and flags
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int IW = 18,
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] instr,
   input  logic          instr_valid,
   output logic          instr_ready,
   output logic [AW-1:0] rd0_addr,
   output logic [AW-1:0] rd1_addr,
   output logic [AW-1:0] wr_addr,
   output logic          reg_read,
   output logic          reg_write,
   output logic          alu_src0,
   output logic          alu_src1,
   output logic [2:0]    alu_op,
   output logic [DW:0]   imm,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_ovf,
   input  logic          alu_zero,
   output logic [DW:0]   wr_data,
   output logic          done,
   output logic          flag_ovf,
   output logic          flag_zero
);

   state_t        state;
   logic [IW-1:0] instr_q;
   logic          ovf_q;
   logic          zero_q;
   logic          wen;
   logic          clear_q;

   // Decoded controls are pure wiring from the instruction register, so they
   // stay registered outputs and hold from DECODE through WB.
   alu_seq_decode #(
      .IW (IW),
      .DW (DW),
      .AW (AW)
   ) u_decode (
      .instr  (instr_q),
      .op     (alu_op),
      .imm_en (alu_src1),
      .zsrc   (alu_src0),
      .wen    (wen),
      .dst    (wr_addr),
      .src0   (rd0_addr),
      .rd1    (rd1_addr),
      .imm    (imm)
   );

`ifdef ALU_SEQ_STICKY_OVF_EN
   assign clear_q = is_clear_flags(instr_q);
`else
   assign clear_q = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         instr_q     <= '0;
         instr_ready <= 1'b1;
         reg_read    <= 1'b0;
         reg_write   <= 1'b0;
         done        <= 1'b0;
         wr_data     <= '0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         flag_ovf    <= 1'b0;
         flag_zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid && instr_ready) begin
                  instr_q     <= instr;
                  instr_ready <= 1'b0;
                  reg_read    <= 1'b1;
                  state       <= DECODE;
               end
            end
            DECODE: begin
               state <= EXEC;
            end
            EXEC: begin
               ovf_q     <= alu_ovf;
               zero_q    <= alu_zero;
               wr_data   <= {alu_result[DW-1], alu_result};
               reg_read  <= 1'b0;
               reg_write <= wen;
               done      <= 1'b1;
               state     <= WB;
            end
            WB: begin
               reg_write   <= 1'b0;
               done        <= 1'b0;
               instr_ready <= 1'b1;
               flag_zero   <= zero_q;
`ifdef ALU_SEQ_STICKY_OVF_EN
               flag_ovf    <= clear_q ? 1'b0 : (flag_ovf | ovf_q);
`else
               flag_ovf    <= ovf_q | clear_q;
`endif
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized self-checking bench for alu_seq_ctrl. The bench
// plays the role of the ALU and predicts every output from the instruction
// field map and retirement rules.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [1:0]  rd0_addr, rd1_addr, wr_addr;
   logic        reg_read, reg_write, alu_src0, alu_src1;
   logic [2:0]  alu_op;
   logic [8:0]  imm, wr_data;
   logic [7:0]  alu_result = '0;
   logic        alu_ovf = 1'b0, alu_zero = 1'b0;
   logic        done, flag_ovf, flag_zero;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic        model_ovf  = 1'b0;
   logic        model_zero = 1'b0;

   alu_seq_ctrl #(.IW(18), .DW(8), .AW(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .rd0_addr    (rd0_addr),
      .rd1_addr    (rd1_addr),
      .wr_addr     (wr_addr),
      .reg_read    (reg_read),
      .reg_write   (reg_write),
      .alu_src0    (alu_src0),
      .alu_src1    (alu_src1),
      .alu_op      (alu_op),
      .imm         (imm),
      .alu_result  (alu_result),
      .alu_ovf     (alu_ovf),
      .alu_zero    (alu_zero),
      .wr_data     (wr_data),
      .done        (done),
      .flag_ovf    (flag_ovf),
      .flag_zero   (flag_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // 8-bit two's-complement value widened to a 9-bit pattern
   function automatic logic [31:0] sx9(input int v8);
      int s;
      s = (v8 >= 128) ? v8 - 256 : v8;
      return 32'(s) & 32'h1FF;
   endfunction

   function automatic logic [17:0] mk(input int op, input int ie, input int zs,
                                      input int we, input int dst, input int s0,
                                      input int i8);
      return 18'((op % 8) * 32768 + (ie % 2) * 16384 + (zs % 2) * 8192 +
                 (we % 2) * 4096 + (dst % 4) * 1024 + (s0 % 4) * 256 + (i8 % 256));
   endfunction

   task automatic chk_decode(input logic [17:0] ins, input string ph);
      int v;
      v = int'(ins);
      check({"alu_op ", ph},   32'(alu_op),   32'(v / 32768));
      check({"alu_src1 ", ph}, 32'(alu_src1), 32'((v / 16384) % 2));
      check({"alu_src0 ", ph}, 32'(alu_src0), 32'((v / 8192) % 2));
      check({"rd0_addr ", ph}, 32'(rd0_addr), 32'((v / 256) % 4));
      check({"rd1_addr ", ph}, 32'(rd1_addr), 32'(v % 4));
      check({"imm ", ph},      32'(imm),      sx9(v % 256));
      check({"reg_read ", ph}, 32'(reg_read), 32'd1);
      check({"instr_ready ", ph}, 32'(instr_ready), 32'd0);
      check({"done ", ph},     32'(done),     32'd0);
      check({"reg_write ", ph}, 32'(reg_write), 32'd0);
   endtask

   // One full instruction: handshake at edge N, checks in cycles N+1..N+4.
   // hold=1 keeps instr_valid high with junk instructions while busy.
   task automatic run_instr(input logic [17:0] ins, input logic [7:0] res,
                            input logic ovf, input logic zero, input bit hold);
      int v;
      bit wen, clr;
      v   = int'(ins);
      wen = ((v / 4096) % 2) == 1;
      clr = (v / 32768 == 0) && ((v / 16384) % 2 == 1) && ((v / 8192) % 2 == 1) &&
            !wen && (v % 256 == 0);
      check("ready idle", 32'(instr_ready), 32'd1);
      instr       = ins;
      instr_valid = 1'b1;
      alu_result  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);                         // N+1 DECODE
      instr_valid = hold;
      instr       = 18'($urandom);
      chk_decode(ins, "dec");
      alu_result  = res;
      alu_ovf     = ovf;
      alu_zero    = zero;
      @(posedge clk);
      @(negedge clk);                         // N+2 EXEC
      instr = 18'($urandom);
      chk_decode(ins, "exe");
      @(posedge clk);
      @(negedge clk);                         // N+3 WB
      alu_result = 8'($urandom);
      alu_ovf    = 1'($urandom);
      alu_zero   = 1'($urandom);
      instr      = 18'($urandom);
      check("wb done", 32'(done), 32'd1);
      check("wb reg_write", 32'(reg_write), 32'(wen));
      check("wb wr_addr", 32'(wr_addr), 32'((v / 1024) % 4));
      check("wb wr_data", 32'(wr_data), sx9(int'(res)));
      check("wb reg_read", 32'(reg_read), 32'd0);
      check("wb ready", 32'(instr_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);                         // N+4 IDLE
      instr_valid = 1'b0;
`ifdef ALU_SEQ_STICKY_OVF_EN
      model_ovf = clr ? 1'b0 : (model_ovf | ovf);
`else
      model_ovf = ovf;
`endif
      model_zero = zero;
      check("post done", 32'(done), 32'd0);
      check("post reg_write", 32'(reg_write), 32'd0);
      check("post ready", 32'(instr_ready), 32'd1);
      check("flag_ovf", 32'(flag_ovf), 32'(model_ovf));
      check("flag_zero", 32'(flag_zero), 32'(model_zero));
   endtask

   task automatic chk_all_zero(input string ph);
      check({"rst ready ", ph}, 32'(instr_ready), 32'd1);
      check({"rst enables ", ph}, {28'd0, reg_read, reg_write, done, alu_src1}, 32'd0);
      check({"rst src0/flags ", ph}, {29'd0, alu_src0, flag_ovf, flag_zero}, 32'd0);
      check({"rst addrs ", ph}, {26'd0, rd0_addr, rd1_addr, wr_addr}, 32'd0);
      check({"rst op/imm ", ph}, {20'd0, alu_op, imm}, 32'd0);
      check({"rst wr_data ", ph}, 32'(wr_data), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk_all_zero("init");
      rst = 1'b1;
      @(negedge clk);

      // Immediate add: dst=2, imm8=FB
      run_instr(mk(0, 1, 1, 1, 2, 0, 8'hFB), 8'hFB, 1'b0, 1'b0, 1'b0);
      // Register operation: src0=1, rd1=3
      run_instr(mk(1, 0, 0, 1, 0, 1, 8'h03), 8'h27, 1'b0, 1'b0, 1'b0);
      // Compare (wen=0) with zero result
      run_instr(mk(5, 1, 0, 0, 1, 2, 8'h10), 8'h00, 1'b0, 1'b1, 1'b0);
      // Back-to-back with instr_valid held high while busy
      run_instr(mk(2, 0, 1, 1, 3, 2, 8'h81), 8'h80, 1'b1, 1'b0, 1'b1);
      run_instr(mk(3, 1, 0, 1, 1, 3, 8'h7F), 8'h7F, 1'b0, 1'b0, 1'b1);
      run_instr(mk(4, 0, 0, 1, 0, 0, 8'h02), 8'hC3, 1'b0, 1'b1, 1'b1);
      // Overflow then non-overflow, then clear-flags encoding
      run_instr(mk(6, 0, 0, 1, 2, 1, 8'h01), 8'h80, 1'b1, 1'b0, 1'b0);
      run_instr(mk(7, 1, 0, 1, 3, 0, 8'h05), 8'h05, 1'b0, 1'b0, 1'b0);
      run_instr(mk(0, 1, 1, 0, 1, 3, 8'h00), 8'h00, 1'b0, 1'b1, 1'b0);

      // Reset during EXEC of a wen=1 instruction
      instr       = mk(1, 1, 0, 1, 2, 1, 8'h44);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all_zero("mid");
      model_ovf  = 1'b0;
      model_zero = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort reg_write", 32'(reg_write), 32'd0);
         check("abort done", 32'(done), 32'd0);
      end

      // Random instructions against the field-map model
      for (int n = 0; n < 40; n++) begin
         logic [17:0] ins;
         ins = 18'($urandom);
         if ($urandom_range(0, 7) == 0) ins = mk(0, 1, 1, 0, $urandom_range(0, 3), $urandom_range(0, 3), 0);
         run_instr(ins, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control FSM that sequences the ALU/register-file datapath, one instruction at a time.
- Accepts 18-bit instruction words over a valid/ready handshake and decodes them into the datapath controls: read/write addresses, read/write enables, mux selects, ALU op and 9-bit immediate.
- Registers the ALU result and flags, then writes the result back to the register file.
- Sits between the instruction source (test sequencer or future fetch unit) and the ALU/register-file datapath.

Parameters:
- IW, 18, instruction word width (field map below is fixed for 18)
- DW, 8, ALU data width; write-back and immediate width is DW+1
- AW, 2, register address width (4 registers)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- instr  in  IW  instruction word
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  controller can accept an instruction
- rd0_addr  out  AW  register-file read port 0 address
- rd1_addr  out  AW  register-file read port 1 address
- wr_addr  out  AW  register-file write address
- reg_read  out  1  register-file read enable
- reg_write  out  1  register-file write enable
- alu_src0  out  1  1 = ALU input 0 forced to zero
- alu_src1  out  1  1 = ALU input 1 taken from the immediate
- alu_op  out  3  ALU operation select
- imm  out  DW+1  sign-extended immediate to the datapath
- alu_result  in  DW  ALU result, signed
- alu_ovf  in  1  ALU overflow flag
- alu_zero  in  1  ALU zero flag
- wr_data  out  DW+1  write-back data
- done  out  1  one-cycle pulse when an instruction retires
- flag_ovf  out  1  overflow flag of the last retired instruction
- flag_zero  out  1  zero flag of the last retired instruction

Behaviour:
- Instruction field map:
  - [17:15] op, copied to alu_op
  - [14] imm_en, copied to alu_src1
  - [13] zsrc, copied to alu_src0
  - [12] wen
  - [11:10] dst
  - [9:8] src0
  - [7:0] imm8
- When imm_en=0, rd1_addr = imm8[1:0].
- imm = sign-extension of imm8 to 9 bits, driven from the latched instruction.
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE; fixed 4-cycle occupancy per instruction.
- IDLE:
  - instr_ready=1; all enables 0.
  - On instr_valid & instr_ready, instr is latched into an internal register and the FSM moves to DECODE.
  - instr is sampled only on that edge; later changes are ignored.
- DECODE:
  - instr_ready=0, reg_read=1.
  - rd0_addr, rd1_addr, alu_src0, alu_src1, alu_op and imm are driven from the latched instruction.
  - These outputs hold stable through EXEC and WB.
- EXEC:
  - reg_read=1.
  - At the end of the cycle, alu_result, alu_ovf and alu_zero are captured into internal registers.
- WB:
  - reg_write = wen.
  - wr_addr = dst.
  - wr_data = sign-extended captured result (9 bits).
  - done=1 for this cycle only.
  - flag_ovf and flag_zero update at the end of WB.
  - Next state is IDLE.
- Latency: handshake at edge N; reg_write and done are high in cycle N+3; instr_ready returns high in cycle N+4.
- Back-to-back: a valid held high is accepted every 4 cycles.
- The controller never accepts while busy. instr_valid held high outside IDLE has no effect.
- A write-back to a register that the next instruction reads is safe: the register file completes the write before the next DECODE.
- Reset values (asynchronous, whenever rst=0):
  - State IDLE; instr_ready=1.
  - All enables, done, alu_src0, alu_src1 and flags = 0.
  - Addresses, alu_op, imm and wr_data = 0.
- Reset asserted mid-instruction aborts it. No reg_write is issued and no done pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- wen=0: the FSM runs all states normally, done pulses and the flags update, but reg_write stays 0 (compare/NOP usage).

Optional Feature:
- Macro: ALU_SEQ_STICKY_OVF_EN.
- Defined:
  - flag_ovf is sticky. It is set by any retired instruction with ovf=1.
  - It is cleared only by reset, or by retiring an instruction with op=3'b000, zsrc=1, imm_en=1, imm8=0, wen=0 (the "clear flags" encoding).
- Undefined: flag_ovf reflects only the last retired instruction.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state encoding constants: IDLE=2'd0, DECODE=2'd1, EXEC=2'd2, WB=2'd3
  - instruction field bit positions
  - the clear-flags encoding
- One sub-module, alu_seq_decode: combinational field extraction and immediate sign-extension from the latched instruction word.

Test Plan:
- Reset mid-flight: pulse rst low during EXEC of an instruction with wen=1 -> reg_write never asserts, done never pulses, instr_ready=1 immediately, all outputs 0.
- Immediate add: instr op=ADD, imm_en=1, zsrc=1, wen=1, dst=2, imm8=8'hFB -> imm=9'h1FB; alu_src0=1 and alu_src1=1 during DECODE/EXEC; with alu_result=8'hFB -> wr_addr=2, wr_data=9'h1FB, reg_write and done high exactly 3 cycles after the handshake.
- Register operation: src0=1, imm8[1:0]=3, imm_en=0 -> rd0_addr=1, rd1_addr=3, reg_read high for exactly 2 cycles, alu_src1=0.
- Back-to-back: instr_valid held high with 3 distinct instructions -> accepted at cycles 0, 4, 8; three done pulses at cycles 3, 7, 11; instr_ready low in between.
- Compare: wen=0, alu_zero=1 -> no reg_write, done pulses, flag_zero=1 after WB.
- Sticky overflow (with ALU_SEQ_STICKY_OVF_EN): an ovf=1 instruction, then an ovf=0 instruction -> flag_ovf stays 1 until the clear-flags encoding retires; without the macro, flag_ovf=0 after the second instruction.
